pokey_audreg_arbiter: RTL and testbench
=======================================

Name: pokey_audreg_arbiter

Overview:
- Shares the audio-register write port of freq_control (AUDF1-4 strobes, AUDCTL, STIMER, D bus) between two requesters: the CPU bus interface and an on-chip tune sequencer.
- Arbitrates the two requesters, buffers sequencer writes, and keeps 16-bit AUDF pair writes atomic.
- Holds each strobe and its data until an enn-qualified cycle, so freq_control's negedge/enn capture always sees exactly one write.

Parameters:
- SEQ_DEPTH, 4, sequencer FIFO entries (power of 2, 2..16).
- CPU_PRIO, 1: 1 = CPU has fixed priority; 0 = round-robin between the two requesters.
- LOCK_TIMEOUT, 15: cycles a lock is held while waiting for the paired sequencer write.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enn  in  1  negative-phase enable, same signal as used by freq_control.
- cpu_req  in  1  CPU write request, level; held until cpu_ack.
- cpu_addr  in  4  CPU register address.
- cpu_data  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse; the CPU write was issued or dropped.
- seq_valid  in  1  sequencer push valid.
- seq_addr  in  4  sequencer register address.
- seq_data  in  8  sequencer write data.
- seq_lock  in  1  this entry is the first half of an atomic pair.
- seq_ready  out  1  FIFO not full.
- D  out  8  data to freq_control.
- AddrW  out  10  one-hot write strobes for addresses 0-9; bit0/2/4/6 drive Addr0w/2w/4w/6w, bit9 drives Addr9w.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- addr_err  out  1  sticky flag: a write to address A-F was dropped.

Behaviour:
- Reset (synchronous): FSM to IDLE, FIFO emptied, D=0, AddrW=0, cpu_ack=0, seq_ready=1, busy=0, addr_err=0, round-robin pointer set to CPU.
- Sequencer push: accepted when seq_valid && seq_ready. The entry {addr, data, lock} enters the FIFO at the clock edge. seq_ready = !full, registered, updated the same cycle as the push or pop.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, but seq_ready stays 0 that cycle; no overflow.
- IDLE: choose a source among cpu_req and FIFO non-empty.
  - CPU_PRIO=1: CPU wins whenever it is requesting.
  - CPU_PRIO=0: round-robin; the pointer flips to the other source after each grant.
- Grant of an address A-F: no strobe. For the CPU, pulse cpu_ack the next cycle; for the sequencer, pop the entry. Set addr_err. Return to IDLE.
- ISSUE: AddrW = onehot(addr) and D = data, registered, from the first cycle after the grant.
  - Held until a cycle in which enn=1; AddrW drops to 0 the following cycle. Strobe width is 1..N cycles and always ends with an enn cycle.
  - D holds its last value after the strobe drops.
  - At the enn cycle: a CPU grant pulses cpu_ack next cycle; a sequencer grant pops the FIFO.
- Next state after ISSUE: LOCKWAIT if this was a sequencer entry with lock=1, else IDLE.
- LOCKWAIT: the CPU is blocked.
  - When the FIFO is non-empty, issue the head entry regardless of arbitration.
  - After LOCK_TIMEOUT cycles with the FIFO empty, go to IDLE without issuing.
  - A chained lock (the second entry also has lock=1) extends the lock to the next entry.
- Throughput: at most one write every 2 cycles when enn is high continuously.
- Reset mid-ISSUE: the strobe drops at the next edge, and the pending write is lost without an ack.

Decomposition:
- pokey_pkg holds:
  - address constants AUDF1..AUDF4 = 0/2/4/6, AUDC1..4 = 1/3/5/7, AUDCTL=8, STIMER=9;
  - the FSM state enum IDLE/ISSUE/LOCKWAIT;
  - the FIFO entry struct {addr[3:0], data[7:0], lock}.
- One sub-module: audreg_fifo, a synchronous FIFO with depth SEQ_DEPTH and full/empty flags.

Test Plan:
- enn toggling 1-of-2; CPU writes addr 0, data 0x55 -> AddrW=0x001 and D=0x55 from grant+1 until the first enn=1 cycle; exactly one enn-high strobe cycle; cpu_ack pulses once.
- CPU_PRIO=1; cpu_req (addr 2) and a sequencer entry (addr 4) in the same cycle -> CPU strobe (bit2) issued first, then sequencer strobe (bit4). With CPU_PRIO=0 and back-to-back requests, grants alternate.
- Sequencer pushes {0,0x34,lock=1}, then {2,0x12,0} 5 cycles later, with cpu_req active throughout -> strobe bit0 then bit2 with no CPU write between them; CPU is served afterwards.
- Sequencer pushes a lock entry with no follower -> LOCKWAIT exits after 15 cycles, then the CPU write is issued.
- Five pushes with enn=0 held -> seq_ready=0 after the 4th push, and the 5th (valid held) is accepted only after the first pop once enn rises. Data order is preserved.
- CPU write to addr 0xC -> no AddrW bit, cpu_ack pulses, addr_err=1 and remains 1 until reset. Reset asserted during ISSUE -> AddrW=0 and busy=0 the next cycle.

Source files
------------

// File: rtl/pokey_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pokey_pkg
// Brief   : Shared types and constants for the POKEY audio-register arbiter.
// Revision: 1.0
// ============================================================================
package pokey_pkg;

    localparam logic [3:0] AUDF1  = 4'd0;
    localparam logic [3:0] AUDC1  = 4'd1;
    localparam logic [3:0] AUDF2  = 4'd2;
    localparam logic [3:0] AUDC2  = 4'd3;
    localparam logic [3:0] AUDF3  = 4'd4;
    localparam logic [3:0] AUDC3  = 4'd5;
    localparam logic [3:0] AUDF4  = 4'd6;
    localparam logic [3:0] AUDC4  = 4'd7;
    localparam logic [3:0] AUDCTL = 4'd8;
    localparam logic [3:0] STIMER = 4'd9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        LOCKWAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       lock;
    } seq_entry_t;

    function automatic logic addr_is_valid(input logic [3:0] addr);
        return (addr <= STIMER);
    endfunction

    function automatic logic [9:0] addr_onehot(input logic [3:0] addr);
        return 10'b1 << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audreg_fifo.sv
`default_nettype none
// ============================================================================
// Module  : audreg_fifo
// Brief   : Synchronous FIFO of sequencer writes with registered ready flag.
// Revision: 1.0
// ============================================================================
module audreg_fifo
    import pokey_pkg::*;
#(
    parameter int SEQ_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  seq_entry_t wr_entry,
    input  logic       pop,
    output seq_entry_t rd_entry,
    output logic       empty,
    output logic       ready
);

    localparam int              AW         = $clog2(SEQ_DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(SEQ_DEPTH);

    seq_entry_t      r_mem [SEQ_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_next;
    logic            w_do_push;
    logic            w_do_pop;

    // ready is registered, so a push in the cycle a full FIFO pops is refused
    assign w_do_push = push && ready;
    assign w_do_pop  = pop && !empty;
    assign empty     = (r_count == '0);
    assign rd_entry  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            ready    <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            ready   <= (w_count_next != FULL_COUNT);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pokey_audreg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pokey_audreg_arbiter
// Brief   : Shares the freq_control audio-register write port between CPU and
//           tune sequencer, holding each strobe until an enn cycle.
// Revision: 1.0
// ============================================================================
module pokey_audreg_arbiter
    import pokey_pkg::*;
#(
    parameter int SEQ_DEPTH    = 4,
    parameter bit CPU_PRIO     = 1'b1,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enn,
    input  logic       cpu_req,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_data,
    output logic       cpu_ack,
    input  logic       seq_valid,
    input  logic [3:0] seq_addr,
    input  logic [7:0] seq_data,
    input  logic       seq_lock,
    output logic       seq_ready,
    output logic [7:0] D,
    output logic [9:0] AddrW,
    output logic       busy,
    output logic       addr_err
);

    localparam int            CW        = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    seq_entry_t    w_head;
    seq_entry_t    w_push_entry;
    logic          w_empty;
    logic          w_pop;
    logic          w_cpu_want;
    logic          w_seq_want;
    logic          w_seq_wins;
    logic          w_take_cpu;
    logic          w_take_seq;
    logic [3:0]    w_sel_addr;
    logic [7:0]    w_sel_data;

    arb_state_t    r_state;
    logic          r_src_seq;
    logic          r_lock;
    logic          r_rr_seq;
    logic [CW-1:0] r_lock_cnt;

    assign w_push_entry = '{addr: seq_addr, data: seq_data, lock: seq_lock};

    // The CPU holds cpu_req through the ack cycle; ignore it then to avoid a replay.
    assign w_cpu_want = cpu_req && !cpu_ack;
    assign w_seq_want = !w_empty;
    assign w_seq_wins = CPU_PRIO ? (w_seq_want && !w_cpu_want)
                                 : (w_seq_want && (!w_cpu_want || r_rr_seq));

    assign w_take_seq = ((r_state == IDLE) && w_seq_wins) || ((r_state == LOCKWAIT) && w_seq_want);
    assign w_take_cpu = (r_state == IDLE) && w_cpu_want && !w_seq_wins;
    assign w_sel_addr = w_take_seq ? w_head.addr : cpu_addr;
    assign w_sel_data = w_take_seq ? w_head.data : cpu_data;

    // Sequencer entries leave the FIFO when their strobe completes or when dropped.
    assign w_pop = ((r_state == ISSUE) && enn && r_src_seq) ||
                   (w_take_seq && !addr_is_valid(w_head.addr));
    assign busy  = (r_state != IDLE) || !w_empty;

    audreg_fifo #(
        .SEQ_DEPTH (SEQ_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (seq_valid),
        .wr_entry (w_push_entry),
        .pop      (w_pop),
        .rd_entry (w_head),
        .empty    (w_empty),
        .ready    (seq_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_src_seq  <= 1'b0;
            r_lock     <= 1'b0;
            r_rr_seq   <= 1'b0;
            r_lock_cnt <= '0;
            D          <= '0;
            AddrW      <= '0;
            cpu_ack    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            if (r_state == ISSUE) begin
                if (enn) begin
                    AddrW      <= '0;
                    cpu_ack    <= !r_src_seq;
                    r_lock_cnt <= '0;
                    r_state    <= (r_src_seq && r_lock) ? LOCKWAIT : IDLE;
                end
            end else if (w_take_cpu || w_take_seq) begin
                r_rr_seq <= !w_take_seq;
                if (addr_is_valid(w_sel_addr)) begin
                    AddrW     <= addr_onehot(w_sel_addr);
                    D         <= w_sel_data;
                    r_src_seq <= w_take_seq;
                    r_lock    <= w_take_seq && w_head.lock;
                    r_state   <= ISSUE;
                end else begin
                    addr_err <= 1'b1;
                    cpu_ack  <= w_take_cpu;
                    r_state  <= IDLE;
                end
            end else if (r_state == LOCKWAIT) begin
                if (r_lock_cnt == LOCK_LAST) begin
                    r_state <= IDLE;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pokey_audreg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pokey_audreg_arbiter
// Brief   : Directed self-checking bench for pokey_audreg_arbiter.
// Revision: 1.0
// ============================================================================
module tb_pokey_audreg_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enn = 1'b0;
    logic       cpu_req = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic [7:0] cpu_data = '0;
    logic       seq_valid = 1'b0;
    logic [3:0] seq_addr = '0;
    logic [7:0] seq_data = '0;
    logic       seq_lock = 1'b0;

    logic       cpu_ack, seq_ready, busy, addr_err;
    logic [7:0] D;
    logic [9:0] AddrW;
    logic       rr_cpu_ack, rr_seq_ready, rr_busy, rr_addr_err;
    logic [7:0] rr_D;
    logic [9:0] rr_AddrW;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pokey_audreg_arbiter #(.SEQ_DEPTH(4), .CPU_PRIO(1'b1), .LOCK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .enn(enn),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .seq_valid(seq_valid), .seq_addr(seq_addr), .seq_data(seq_data), .seq_lock(seq_lock),
        .seq_ready(seq_ready), .D(D), .AddrW(AddrW), .busy(busy), .addr_err(addr_err)
    );

    pokey_audreg_arbiter #(.SEQ_DEPTH(4), .CPU_PRIO(1'b0), .LOCK_TIMEOUT(15)) dut_rr (
        .clk(clk), .reset(reset), .enn(enn),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(rr_cpu_ack),
        .seq_valid(seq_valid), .seq_addr(seq_addr), .seq_data(seq_data), .seq_lock(seq_lock),
        .seq_ready(rr_seq_ready), .D(rr_D), .AddrW(rr_AddrW), .busy(rr_busy), .addr_err(rr_addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_set(input logic [3:0] a, input logic [7:0] d, input logic l);
        seq_valid = 1'b1;
        seq_addr  = a;
        seq_data  = d;
        seq_lock  = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fifo_strb [4];
        logic [7:0] fifo_data [4];
        fifo_strb = '{10'h008, 10'h020, 10'h080, 10'h200};
        fifo_data = '{8'h33, 8'h55, 8'h77, 8'h99};

        // Reset state
        tick(); tick();
        chk("rst_addrw", AddrW, 10'h000);
        chk("rst_d", D, 8'h00);
        chk("rst_ack", cpu_ack, 1'b0);
        chk("rst_ready", seq_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", addr_err, 1'b0);
        reset = 1'b0;
        tick();

        // CPU write addr 0 with enn toggling
        enn = 1'b1; cpu_req = 1'b1; cpu_addr = 4'h0; cpu_data = 8'h55;
        tick();
        chk("cpu0_strobe", AddrW, 10'h001);
        chk("cpu0_d", D, 8'h55);
        chk("cpu0_noack", cpu_ack, 1'b0);
        enn = 1'b0;
        tick();
        chk("cpu0_hold", AddrW, 10'h001);
        enn = 1'b1;
        tick();
        chk("cpu0_drop", AddrW, 10'h000);
        chk("cpu0_ack", cpu_ack, 1'b1);
        chk("cpu0_dhold", D, 8'h55);
        cpu_req = 1'b0; enn = 1'b0;
        tick();
        chk("cpu0_ack_once", cpu_ack, 1'b0);
        chk("cpu0_idle", busy, 1'b0);

        // Fixed priority: CPU and sequencer together
        enn = 1'b1; cpu_req = 1'b1; cpu_addr = 4'h2; cpu_data = 8'hA2;
        push_set(4'h4, 8'hB4, 1'b0);
        tick();
        seq_valid = 1'b0;
        chk("prio_cpu_first", AddrW, 10'h004);
        chk("prio_cpu_d", D, 8'hA2);
        tick();
        chk("prio_cpu_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        chk("prio_seq_second", AddrW, 10'h010);
        chk("prio_seq_d", D, 8'hB4);
        tick();
        chk("prio_seq_done", AddrW, 10'h000);
        chk("prio_idle", busy, 1'b0);

        // Locked pair blocks the CPU
        push_set(4'h0, 8'h34, 1'b1);
        tick();
        seq_valid = 1'b0;
        tick();
        chk("lock_first", AddrW, 10'h001);
        chk("lock_first_d", D, 8'h34);
        cpu_req = 1'b1; cpu_addr = 4'h6; cpu_data = 8'h66;
        tick();
        chk("lock_wait0", AddrW, 10'h000);
        chk("lock_busy", busy, 1'b1);
        tick();
        chk("lock_wait1", AddrW, 10'h000);
        tick();
        chk("lock_wait2", AddrW, 10'h000);
        push_set(4'h2, 8'h12, 1'b0);
        tick();
        seq_valid = 1'b0;
        chk("lock_wait3", AddrW, 10'h000);
        tick();
        chk("lock_second", AddrW, 10'h004);
        chk("lock_second_d", D, 8'h12);
        tick();
        chk("lock_second_done", AddrW, 10'h000);
        chk("lock_cpu_noack", cpu_ack, 1'b0);
        tick();
        chk("lock_cpu_after", AddrW, 10'h040);
        chk("lock_cpu_d", D, 8'h66);
        tick();
        chk("lock_cpu_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();

        // Lock with no follower times out
        push_set(4'h4, 8'h44, 1'b1);
        tick();
        seq_valid = 1'b0;
        tick();
        chk("tmo_first", AddrW, 10'h010);
        cpu_req = 1'b1; cpu_addr = 4'h8; cpu_data = 8'h88;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo_blocked", AddrW, 10'h000);
            if (i == 14) chk("tmo_busy_last", busy, 1'b1);
            if (i == 15) chk("tmo_exit_idle", busy, 1'b0);
        end
        tick();
        chk("tmo_cpu_strobe", AddrW, 10'h100);
        chk("tmo_cpu_d", D, 8'h88);
        tick();
        chk("tmo_cpu_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();

        // FIFO fill with enn held low
        enn = 1'b0;
        push_set(4'h1, 8'h11, 1'b0);
        tick();
        push_set(4'h3, 8'h33, 1'b0);
        tick();
        chk("fill_strobe0", AddrW, 10'h002);
        chk("fill_d0", D, 8'h11);
        push_set(4'h5, 8'h55, 1'b0);
        tick();
        chk("fill_ready3", seq_ready, 1'b1);
        push_set(4'h7, 8'h77, 1'b0);
        tick();
        chk("fill_full", seq_ready, 1'b0);
        push_set(4'h9, 8'h99, 1'b0);
        tick();
        chk("fill_still_full", seq_ready, 1'b0);
        chk("fill_hold", AddrW, 10'h002);
        enn = 1'b1;
        tick();
        chk("fill_pop_drop", AddrW, 10'h000);
        chk("fill_ready_again", seq_ready, 1'b1);
        tick();
        seq_valid = 1'b0;
        chk("fill_fifth_in", seq_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("fill_order_strobe", AddrW, fifo_strb[k]);
            chk("fill_order_d", D, fifo_data[k]);
            tick();
            chk("fill_order_drop", AddrW, 10'h000);
            if (k < 3) tick();
        end
        chk("fill_drained", busy, 1'b0);

        // Write to unmapped address
        cpu_req = 1'b1; cpu_addr = 4'hC; cpu_data = 8'hEE;
        tick();
        chk("bad_ack", cpu_ack, 1'b1);
        chk("bad_nostrobe", AddrW, 10'h000);
        chk("bad_err", addr_err, 1'b1);
        chk("bad_dkeep", D, 8'h99);
        cpu_req = 1'b0;
        tick();
        chk("bad_ack_once", cpu_ack, 1'b0);
        tick(); tick();
        chk("bad_err_sticky", addr_err, 1'b1);

        // Reset during ISSUE
        enn = 1'b0; cpu_req = 1'b1; cpu_addr = 4'h9; cpu_data = 8'h5A;
        tick();
        chk("rst_issue_strobe", AddrW, 10'h200);
        reset = 1'b1;
        tick();
        chk("rst_issue_drop", AddrW, 10'h000);
        chk("rst_issue_busy", busy, 1'b0);
        chk("rst_issue_err", addr_err, 1'b0);
        reset = 1'b0; cpu_req = 1'b0;
        tick();
        chk("rst_issue_noack", cpu_ack, 1'b0);

        // Round-robin instance: grants alternate under contention
        enn = 1'b1; cpu_req = 1'b1; cpu_addr = 4'h5; cpu_data = 8'hC5;
        tick();
        chk("rr_cpu1", rr_AddrW, 10'h020);
        tick();
        chk("rr_cpu1_ack", rr_cpu_ack, 1'b1);
        cpu_addr = 4'h7; cpu_data = 8'hC7;
        push_set(4'h1, 8'hA1, 1'b0);
        tick();
        push_set(4'h3, 8'hA3, 1'b0);
        chk("rr_gap", rr_AddrW, 10'h000);
        tick();
        seq_valid = 1'b0;
        chk("rr_seq1", rr_AddrW, 10'h002);
        chk("rr_seq1_d", rr_D, 8'hA1);
        tick();
        chk("rr_seq1_drop", rr_AddrW, 10'h000);
        tick();
        chk("rr_cpu2", rr_AddrW, 10'h080);
        chk("rr_cpu2_d", rr_D, 8'hC7);
        tick();
        chk("rr_cpu2_ack", rr_cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        chk("rr_seq2", rr_AddrW, 10'h008);
        chk("rr_seq2_d", rr_D, 8'hA3);
        tick(); tick();
        chk("rr_idle", rr_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
